bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble).
- Sits between the accelerometer sample path and the seven-segment hex driver; produces the per-digit BCD values the hex driver decodes onto HEX0..HEX5.
- Valid/ready on both sides; one conversion in flight at a time.

---
 rtl/bin_to_bcd_seq.sv | 138 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding the hex display driver.
// Optional two's-complement input handling: define BIN_TO_BCD_SIGNED_MAG_EN.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_neg,
    output logic                  out_ovf
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0]      MAX_DEC = pow10(DIGITS) - 64'd1;
    localparam logic [BCD_W-1:0] SAT_BCD = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_sr;
    logic [BCD_W-1:0]   bcd_acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_q;
    logic [BIN_W-1:0]   mag;
    logic               ovf_calc;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_next;
    logic [BIN_W-1:0]   bin_next;
    logic               last;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign last      = (cnt == CNT_W'(BIN_W - 1));

`ifdef BIN_TO_BCD_SIGNED_MAG_EN
    logic neg_q;
    logic neg_out_q;

    // The most negative input negates to itself, which read unsigned is exactly its magnitude.
    assign mag     = in_bin[BIN_W-1] ? (~in_bin + {{(BIN_W-1){1'b0}}, 1'b1}) : in_bin;
    assign out_neg = neg_out_q;
`else
    assign mag     = in_bin;
    assign out_neg = 1'b0;
`endif

    assign ovf_calc = ({{(64-BIN_W){1'b0}}, mag} > MAX_DEC);

    // One double-dabble step: correct every nibble >= 5, then shift {bcd, bin} left by one.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        bcd_adj = bcd_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
        bin_next = {bin_sr[BIN_W-2:0], 1'b0};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_sr    <= '0;
            bcd_acc   <= '0;
            cnt       <= '0;
            ovf_q     <= 1'b0;
            out_bcd   <= '0;
            out_ovf   <= 1'b0;
`ifdef BIN_TO_BCD_SIGNED_MAG_EN
            neg_q     <= 1'b0;
            neg_out_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr  <= mag;
                        bcd_acc <= '0;
                        cnt     <= '0;
                        ovf_q   <= ovf_calc;
`ifdef BIN_TO_BCD_SIGNED_MAG_EN
                        neg_q   <= in_bin[BIN_W-1];
`endif
                    end
                end
                SHIFT: begin
                    bcd_acc <= bcd_next;
                    bin_sr  <= bin_next;
                    cnt     <= cnt + CNT_W'(1);
                    // Results are published on the final shift so out_valid rises BIN_W cycles after capture.
                    if (last) begin
                        out_bcd   <= ovf_q ? SAT_BCD : bcd_next;
                        out_ovf   <= ovf_q;
`ifdef BIN_TO_BCD_SIGNED_MAG_EN
                        neg_out_q <= neg_q;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq; each task drives one scenario and checks inline.
// Expected values adapt when BIN_TO_BCD_SIGNED_MAG_EN is defined.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_bcd;
    logic        out_neg;
    logic        out_ovf;

    int checks   = 0;
    int failures = 0;

    bin_to_bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_neg   (out_neg),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one sample for a single edge; caller ensures in_ready is high.
    task automatic send(input logic [19:0] v);
        in_valid = 1'b1;
        in_bin   = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Cycles from the last sampled edge until out_valid is seen, bounded.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 24'h0 || out_neg !== 1'b0 || out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: valid=%b ready=%b bcd=%h neg=%b ovf=%b, want 0 1 000000 0 0",
                     out_valid, in_ready, out_bcd, out_neg, out_ovf);
        end
    endtask

    task automatic test_basic();
        int cyc;
        out_ready = 1'b1;
        send(20'd123456);
        wait_valid(cyc);
        checks++;
        if (cyc !== 20) begin
            failures++;
            $display("FAIL basic_latency: got %0d cycles, want 20", cyc);
        end
        checks++;
        if (out_bcd !== 24'h123456 || out_ovf !== 1'b0 || out_neg !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: bcd=%h ovf=%b neg=%b, want 123456 0 0", out_bcd, out_ovf, out_neg);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_return_idle: ready=%b valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [23:0] exp2;
        logic        neg2;
`ifdef BIN_TO_BCD_SIGNED_MAG_EN
        exp2 = 24'h048577; neg2 = 1'b1;
`else
        exp2 = 24'h999999; neg2 = 1'b0;
`endif
        out_ready = 1'b1;
        send(20'd0);
        // Hold the second sample pending throughout the first conversion.
        in_valid = 1'b1;
        in_bin   = 20'd999999;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy_ready: ready=%b, want 0", in_ready);
        end
        wait_valid(cyc);
        checks++;
        if (cyc !== 20 || out_bcd !== 24'h000000 || out_ovf !== 1'b0 || out_neg !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: cyc=%0d bcd=%h ovf=%b neg=%b, want 20 000000 0 0", cyc, out_bcd, out_ovf, out_neg);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap: ready=%b valid=%b, want 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(cyc);
        checks++;
        if (cyc !== 20 || out_bcd !== exp2 || out_ovf !== 1'b0 || out_neg !== neg2) begin
            failures++;
            $display("FAIL b2b_second: cyc=%0d bcd=%h ovf=%b neg=%b, want 20 %h 0 %b", cyc, out_bcd, out_ovf, out_neg, exp2, neg2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        int cyc;
        logic [19:0] vin  [2];
        logic [23:0] ebcd [2];
        logic        eovf [2];
        logic        eneg [2];
        vin[0] = 20'd1000000;
        vin[1] = 20'd1048575;
`ifdef BIN_TO_BCD_SIGNED_MAG_EN
        ebcd[0] = 24'h048576; eovf[0] = 1'b0; eneg[0] = 1'b1;
        ebcd[1] = 24'h000001; eovf[1] = 1'b0; eneg[1] = 1'b1;
`else
        ebcd[0] = 24'h999999; eovf[0] = 1'b1; eneg[0] = 1'b0;
        ebcd[1] = 24'h999999; eovf[1] = 1'b1; eneg[1] = 1'b0;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(vin[i]);
            wait_valid(cyc);
            checks++;
            if (cyc !== 20 || out_bcd !== ebcd[i] || out_ovf !== eovf[i] || out_neg !== eneg[i]) begin
                failures++;
                $display("FAIL overflow_%0d: cyc=%0d bcd=%h ovf=%b neg=%b, want 20 %h %b %b",
                         vin[i], cyc, out_bcd, out_ovf, out_neg, ebcd[i], eovf[i], eneg[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad;
        out_ready = 1'b0;
        send(20'd4321);
        wait_valid(cyc);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bcd !== 24'h004321) bad++;
        end
        checks++;
        if (cyc !== 20 || bad !== 0) begin
            failures++;
            $display("FAIL backpressure_hold: cyc=%0d unstable_cycles=%0d bcd=%h, want 20 0 004321", cyc, bad, out_bcd);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 24'h004321 || out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: valid=%b ready=%b bcd=%h ovf=%b, want 0 1 004321 0",
                     out_valid, in_ready, out_bcd, out_ovf);
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        int pulses;
        out_ready = 1'b1;
        send(20'd555555);
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 24'h0 || out_ovf !== 1'b0 || out_neg !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state: valid=%b ready=%b bcd=%h ovf=%b neg=%b, want 0 1 000000 0 0",
                     out_valid, in_ready, out_bcd, out_ovf, out_neg);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL midreset_no_valid: saw %0d valid cycles, want 0", pulses);
        end
        send(20'd7);
        wait_valid(cyc);
        checks++;
        if (cyc !== 20 || out_bcd !== 24'h000007 || out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL midreset_recover: cyc=%0d bcd=%h ovf=%b, want 20 000007 0", cyc, out_bcd, out_ovf);
        end
        @(posedge clk); #1;
    endtask

`ifdef BIN_TO_BCD_SIGNED_MAG_EN
    task automatic test_signed();
        int cyc;
        logic [19:0] vin  [3];
        logic [23:0] ebcd [3];
        logic        eneg [3];
        vin[0] = 20'hFFFD6; ebcd[0] = 24'h000042; eneg[0] = 1'b1;
        vin[1] = 20'h80000; ebcd[1] = 24'h524288; eneg[1] = 1'b1;
        vin[2] = 20'h00000; ebcd[2] = 24'h000000; eneg[2] = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(vin[i]);
            wait_valid(cyc);
            checks++;
            if (cyc !== 20 || out_bcd !== ebcd[i] || out_neg !== eneg[i] || out_ovf !== 1'b0) begin
                failures++;
                $display("FAIL signed_%h: cyc=%0d bcd=%h neg=%b ovf=%b, want 20 %h %b 0",
                         vin[i], cyc, out_bcd, out_neg, out_ovf, ebcd[i], eneg[i]);
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_bin    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_mid_reset();
`ifdef BIN_TO_BCD_SIGNED_MAG_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
